crc_par_lfsr: RTL and testbench
===============================

// Module: crc_par_lfsr
// PURPOSE
//  Parametrised unfolded (PAR bits/cycle) CRC generator; successor of the fixed 2-level CRC engine.
//  Accepts a message of msg_len bits MSB-first over a valid/ready stream and returns the
//  CRC_W-bit remainder of M(x)*x^CRC_W mod G(x). Two modes: direct LFSR, or augmented division
//  (message followed by CRC_W zero bits). Sits between the framer and the transmit serializer.
// PARAMETERS
//  CRC_W    8      CRC degree / remainder width
//  POLY     8'h07  generator taps, x^CRC_W implicit (0x07 = x^8+x^2+x+1)
//  INIT     8'h00  register preset applied on start
//  PAR      2      bits processed per cycle (unfolding factor); CRC_W % PAR == 0 required
//  AUGMENT  0      0: direct mode; 1: augmented long-division mode (zero-flush phase)
//  LEN_W    16     width of msg_len
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        asynchronous, active-low reset
//  start      in   1        pulse: begin new message (accepted in IDLE only)
//  msg_len    in   LEN_W    message length in bits, sampled on accepted start; multiple of PAR
//  in_valid   in   1        in_data valid
//  in_ready   out  1        engine accepts a beat (beat transfers when in_valid & in_ready)
//  in_data    in   PAR      message bits; in_data[PAR-1] is the earliest bit
//  busy       out  1        high in RUN/FLUSH
//  crc_valid  out  1        one-cycle pulse: crc_out holds the final remainder
//  crc_out    out  CRC_W    result; stable from crc_valid until next accepted start
//  len_err    out  1        sticky until next accepted start: msg_len % PAR != 0 at start
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE; crc reg=INIT; in_ready=0, busy=0, crc_valid=0,
//   crc_out=0, len_err=0; bit counter=0. Reset mid-message discards the message, no crc_valid.
//  FSM IDLE -> RUN -> (FLUSH if AUGMENT) -> DONE -> IDLE.
//   IDLE: in_ready=0. start: crc reg<=INIT, cnt<=msg_len, len_err<=(msg_len%PAR!=0).
//     len_err=1 or msg_len==0 -> DONE directly (crc reg stays INIT).
//     Otherwise -> RUN.
//   RUN: in_ready=1. Each accepted beat: cnt-=PAR; crc reg <= PAR-step update
//     (direct: per bit fb=reg[MSB]^d, reg=(reg<<1)^(fb?POLY:0); augmented: per bit
//     fb=reg[MSB], reg=((reg<<1)|d)^(fb?POLY:0)). Unrolled combinationally, one register stage.
//     Beat making cnt==0 -> FLUSH (AUGMENT=1) or DONE. No beat: state and reg hold.
//   FLUSH: in_ready=0; shifts PAR zero bits/cycle for CRC_W/PAR cycles, then DONE.
//   DONE: crc_out<=crc reg, crc_valid=1 for exactly this one cycle; -> IDLE.
//  Latency from last accepted beat to crc_valid: 1 cycle (direct), 1+CRC_W/PAR (augmented).
//  Both modes give identical crc_out for INIT=0; for INIT!=0 augmented presets the dividend.
//  start while busy or in DONE: ignored, no effect on current message or len_err.
//  start in same cycle as DONE: ignored; next start accepted in IDLE only (1 idle cycle min).
//  in_valid outside RUN: ignored (in_ready=0). busy=1 exactly in RUN and FLUSH.
//  cnt is LEN_W bits, decremented only on accepted beats; never wraps (exit at 0).
// TESTING
//  1 Direct, PAR=2: "123456789" ASCII (72 bits, 36 beats), in_valid always 1 ->
//    crc_out=8'hF4, crc_valid pulses 1 cycle after beat 36, single pulse.
//  2 Single byte 8'hFF then 8'h01 as separate messages -> 8'hF3, then 8'h07; crc_out holds
//    8'hF3 until second start accepted.
//  3 AUGMENT=1, same vector as 1 with random in_valid gaps -> 8'hF4, crc_valid exactly
//    5 cycles after last accepted beat; busy high through FLUSH.
//  4 msg_len=0 -> crc_out=INIT, crc_valid next cycle+1; msg_len=7 -> len_err=1, no beats taken.
//  5 start pulsed mid-message (beat 10 of 36) -> ignored, final CRC still 8'hF4.
//  6 reset asserted at beat 20, released, new 8'h01 message -> no stale pulse, crc_out=8'h07;
//    sweep PAR in {1,2,4,8}: all give 8'hF4 for vector 1.

Source files
------------

// File: rtl/crc_par_lfsr.sv
`default_nettype none
// ============================================================================
// Module     : crc_par_lfsr
// Description: Unfolded CRC generator taking PAR message bits per cycle over a
//              valid/ready stream; direct LFSR or augmented long division.
// Revision   : 1.0 - initial release
// ============================================================================
module crc_par_lfsr #(
    parameter int               CRC_W   = 8,
    parameter logic [CRC_W-1:0] POLY    = 8'h07,
    parameter logic [CRC_W-1:0] INIT    = 8'h00,
    parameter int               PAR     = 2,
    parameter int               AUGMENT = 0,
    parameter int               LEN_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PAR-1:0]   in_data,
    output logic             busy,
    output logic             crc_valid,
    output logic [CRC_W-1:0] crc_out,
    output logic             len_err
);

    localparam int FLUSH_CYC = CRC_W / PAR;
    localparam int FC_W      = $clog2(FLUSH_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_d;
    logic [CRC_W-1:0] r_crc;
    logic [CRC_W-1:0] w_crc_d;
    logic [CRC_W-1:0] w_step;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_d;
    logic [FC_W-1:0]  r_flush_cnt;
    logic [FC_W-1:0]  w_flush_d;
    logic             r_len_err;
    logic             w_len_err_d;
    logic             w_len_bad;
    logic [PAR-1:0]   w_bits;
    logic             w_fb;

    assign w_len_bad = (msg_len % LEN_W'(PAR)) != '0;

    // PAR single-bit LFSR steps unrolled; in_data[PAR-1] is shifted in first.
    // During FLUSH the augmented divider consumes zeros instead of data.
    always_comb begin
        w_bits = (r_state == S_FLUSH) ? '0 : in_data;
        w_step = r_crc;
        w_fb   = 1'b0;
        for (int i = 0; i < PAR; i++) begin
            if (AUGMENT != 0) begin
                w_fb   = w_step[CRC_W-1];
                w_step = {w_step[CRC_W-2:0], w_bits[PAR-1-i]} ^ (w_fb ? POLY : '0);
            end else begin
                w_fb   = w_step[CRC_W-1] ^ w_bits[PAR-1-i];
                w_step = {w_step[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
            end
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_crc_d     = r_crc;
        w_cnt_d     = r_cnt;
        w_flush_d   = r_flush_cnt;
        w_len_err_d = r_len_err;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_crc_d     = INIT;
                    w_cnt_d     = msg_len;
                    w_len_err_d = w_len_bad;
                    w_state_d   = (w_len_bad || msg_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (in_valid) begin
                    w_crc_d = w_step;
                    w_cnt_d = r_cnt - LEN_W'(PAR);
                    if (r_cnt <= LEN_W'(PAR)) begin
                        if (AUGMENT != 0) begin
                            w_state_d = S_FLUSH;
                            w_flush_d = FC_W'(FLUSH_CYC);
                        end else begin
                            w_state_d = S_DONE;
                        end
                    end
                end
            end
            S_FLUSH: begin
                w_crc_d   = w_step;
                w_flush_d = r_flush_cnt - FC_W'(1);
                if (r_flush_cnt == FC_W'(1)) begin
                    w_state_d = S_DONE;
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // crc_out is captured on the edge entering DONE so it is already valid
    // while crc_valid is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_crc       <= INIT;
            r_cnt       <= '0;
            r_flush_cnt <= '0;
            r_len_err   <= 1'b0;
            crc_out     <= '0;
        end else begin
            r_state     <= w_state_d;
            r_crc       <= w_crc_d;
            r_cnt       <= w_cnt_d;
            r_flush_cnt <= w_flush_d;
            r_len_err   <= w_len_err_d;
            if (w_state_d == S_DONE) begin
                crc_out <= w_crc_d;
            end
        end
    end

    assign in_ready  = (r_state == S_RUN);
    assign busy      = (r_state == S_RUN) || (r_state == S_FLUSH);
    assign crc_valid = (r_state == S_DONE);
    assign len_err   = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_crc_par_lfsr.sv
`default_nettype none
// ============================================================================
// Module     : tb_crc_par_lfsr
// Description: Directed self-checking bench; five instances cover direct PAR
//              1/2/4/8 and augmented PAR=2 against hand-computed CRC-8 values.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_crc_par_lfsr;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  start    = '0;
    logic [4:0]  in_valid = '0;
    logic [15:0] msg_len [5];
    logic [7:0]  din     [5];
    wire  [4:0]  in_ready;
    wire  [4:0]  busy;
    wire  [4:0]  crc_valid;
    wire  [4:0]  len_err;
    wire  [7:0]  crc     [5];

    int total = 0;
    int bad   = 0;

    localparam logic [71:0] C_VEC = "123456789";

    always #5 clk = ~clk;

    // Instance 0: direct PAR=2, 1: augmented PAR=2, 2/3/4: direct PAR=1/4/8
    for (genvar gi = 0; gi < 5; gi++) begin : g_dut
        localparam int P = (gi == 2) ? 1 : (gi == 3) ? 4 : (gi == 4) ? 8 : 2;
        localparam int A = (gi == 1) ? 1 : 0;
        crc_par_lfsr #(
            .CRC_W(8), .POLY(8'h07), .INIT(8'h00),
            .PAR(P), .AUGMENT(A), .LEN_W(16)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .start    (start[gi]),
            .msg_len  (msg_len[gi]),
            .in_valid (in_valid[gi]),
            .in_ready (in_ready[gi]),
            .in_data  (din[gi][P-1:0]),
            .busy     (busy[gi]),
            .crc_valid(crc_valid[gi]),
            .crc_out  (crc[gi]),
            .len_err  (len_err[gi])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends one message; returns cycles from last accepted beat to crc_valid,
    // number of crc_valid pulses seen, and whether busy held until DONE.
    task automatic run_msg(input int idx, input int p, input int nbits,
                           input logic [71:0] m, input bit gaps,
                           input int inj, input int abort_at,
                           output int lat, output int pulses, output bit busy_ok);
        int  b;
        int  guard;
        bit  acc;
        logic [7:0] d;
        b = 0; guard = 0; lat = 0; pulses = 0; busy_ok = 1'b1;
        @(negedge clk);
        start[idx]   = 1'b1;
        msg_len[idx] = 16'(nbits);
        @(posedge clk);
        #1 start[idx] = 1'b0;
        while (b < nbits / p && b != abort_at) begin
            @(negedge clk);
            d = '0;
            for (int j = 0; j < p; j++) d[p-1-j] = m[nbits-1-b*p-j];
            din[idx]      = d;
            in_valid[idx] = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            start[idx]    = (inj >= 0 && b == inj);
            if (inj >= 0 && b == inj) msg_len[idx] = 16'd7;
            acc = in_valid[idx] & in_ready[idx];
            @(posedge clk);
            if (acc) b++;
            guard++;
            if (guard > 2000) begin
                check("beat_timeout", 32'(b), 32'(nbits / p));
                break;
            end
        end
        if (b == abort_at) return;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                in_valid[idx] = 1'b0;
                start[idx]    = 1'b0;
            end
            if (crc_valid[idx]) begin
                pulses++;
                if (lat == 0) lat = k;
            end else if (lat == 0 && !busy[idx]) begin
                busy_ok = 1'b0;
            end
        end
    endtask

    initial begin
        int lat, pulses;
        bit bok;
        int stray;
        for (int i = 0; i < 5; i++) begin
            msg_len[i] = '0;
            din[i]     = '0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_crc_out",   32'(crc[0]), 32'h00);
        check("rst_in_ready",  32'(in_ready[0]), 32'h0);
        check("rst_busy",      32'(busy[0]), 32'h0);
        check("rst_crc_valid", 32'(crc_valid[0]), 32'h0);
        check("rst_len_err",   32'(len_err[0]), 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Check string, direct PAR=2
        run_msg(0, 2, 72, C_VEC, 1'b0, -1, -1, lat, pulses, bok);
        check("t1_crc",    32'(crc[0]), 32'hF4);
        check("t1_lat",    32'(lat), 32'd1);
        check("t1_pulses", 32'(pulses), 32'd1);

        // Single-byte messages and result hold
        run_msg(0, 2, 8, 72'hFF, 1'b0, -1, -1, lat, pulses, bok);
        check("t2_crc_ff", 32'(crc[0]), 32'hF3);
        repeat (3) @(negedge clk);
        check("t2_hold",   32'(crc[0]), 32'hF3);
        run_msg(0, 2, 8, 72'h01, 1'b0, -1, -1, lat, pulses, bok);
        check("t2_crc_01", 32'(crc[0]), 32'h07);

        // Augmented mode with random gaps
        run_msg(1, 2, 72, C_VEC, 1'b1, -1, -1, lat, pulses, bok);
        check("t3_crc",     32'(crc[1]), 32'hF4);
        check("t3_lat",     32'(lat), 32'd5);
        check("t3_busy",    32'(bok), 32'd1);
        check("t3_pulses",  32'(pulses), 32'd1);

        // Length not a multiple of PAR
        @(negedge clk);
        start[0] = 1'b1; msg_len[0] = 16'd7; in_valid[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        @(negedge clk);
        check("t4_len_err",   32'(len_err[0]), 32'h1);
        check("t4_valid",     32'(crc_valid[0]), 32'h1);
        check("t4_no_ready",  32'(in_ready[0]), 32'h0);
        check("t4_crc_init",  32'(crc[0]), 32'h00);
        repeat (2) @(negedge clk);
        check("t4_sticky",    32'(len_err[0]), 32'h1);
        check("t4_idle_busy", 32'(busy[0]), 32'h0);
        in_valid[0] = 1'b0;

        // Start pulse mid-message is ignored
        run_msg(0, 2, 72, C_VEC, 1'b0, 10, -1, lat, pulses, bok);
        check("t5_crc",      32'(crc[0]), 32'hF4);
        check("t5_len_err",  32'(len_err[0]), 32'h0);
        check("t5_pulses",   32'(pulses), 32'd1);

        // Zero-length message returns INIT
        run_msg(0, 2, 0, 72'h0, 1'b0, -1, -1, lat, pulses, bok);
        check("t4_zero_crc", 32'(crc[0]), 32'h00);
        check("t4_zero_lat", 32'(lat), 32'd1);

        // Reset mid-message
        run_msg(0, 2, 72, C_VEC, 1'b0, -1, 20, lat, pulses, bok);
        @(negedge clk);
        in_valid[0] = 1'b0;
        reset = 1'b0;
        #1;
        check("t6_rst_busy",  32'(busy[0]), 32'h0);
        check("t6_rst_ready", 32'(in_ready[0]), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        stray = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (crc_valid[0]) stray++;
        end
        check("t6_no_stale", 32'(stray), 32'd0);
        run_msg(0, 2, 8, 72'h01, 1'b0, -1, -1, lat, pulses, bok);
        check("t6_crc_01",   32'(crc[0]), 32'h07);

        // PAR sweep
        run_msg(2, 1, 72, C_VEC, 1'b0, -1, -1, lat, pulses, bok);
        check("sweep_p1_crc", 32'(crc[2]), 32'hF4);
        check("sweep_p1_lat", 32'(lat), 32'd1);
        run_msg(3, 4, 72, C_VEC, 1'b0, -1, -1, lat, pulses, bok);
        check("sweep_p4_crc", 32'(crc[3]), 32'hF4);
        check("sweep_p4_lat", 32'(lat), 32'd1);
        run_msg(4, 8, 72, C_VEC, 1'b1, -1, -1, lat, pulses, bok);
        check("sweep_p8_crc", 32'(crc[4]), 32'hF4);
        check("sweep_p8_lat", 32'(lat), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
